// File: rtl/dm_access_pkg.sv
// dm_access_pkg: shared types, constants and helpers for the data-memory access unit
package dm_access_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;
  localparam logic [3:0] WEB_NONE = 4'b1111;
  function automatic logic is_misaligned(size_e size, logic [1:0] off);
    return (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: byte-lane steering for stores and lane extraction/extension for loads
module dm_lane_align
  import dm_access_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  web,
  output logic [31:0] di,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  // store lane mask/replication and load right-justify plus sign/zero extension
  always_comb begin
    sh = rdata_raw >> {off, 3'b000};
    web = size == SZ_B ? ~(4'b0001 << off) : size == SZ_H ? (off[1] ? 4'b0011 : 4'b1100) : 4'b0000;
    di = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
    rdata = size == SZ_B ? {{24{sh[7] & ~uns}}, sh[7:0]} :
            size == SZ_H ? {{16{sh[15] & ~uns}}, sh[15:0]} : rdata_raw;
  end
endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: single-outstanding load/store front-end driving a word-wide SRAM
module dm_access_unit
  import dm_access_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              dm_oe,
  output logic [3:0]        dm_web,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_di,
  input  logic [31:0]       dm_do
);
  state_e      state;
  size_e       size_q, sz;
  logic [1:0]  off_q, off;
  logic        we_q, uns_q, req_err;
  logic [3:0]  web;
  logic [31:0] di, rdata;
  logic        unused_hi;
  // lane logic sees the live request while idle and the latched one afterwards
  always_comb begin
    sz = state == IDLE ? size_e'(req_size) : size_q;
    off = state == IDLE ? req_addr[1:0] : off_q;
    req_err = is_misaligned(size_e'(req_size), req_addr[1:0]) || size_e'(req_size) == SZ_BAD;
    unused_hi = ^req_addr[31:ADDR_W+2];
  end
  dm_lane_align u_align (
    .size(sz), .off(off), .uns(uns_q), .wdata(req_wdata), .rdata_raw(dm_do),
    .web(web), .di(di), .rdata(rdata)
  );
  // request FSM; every SRAM and response output is a register updated here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      dm_oe <= 1'b0;
      dm_web <= WEB_NONE;
      dm_addr <= '0;
      dm_di <= '0;
      we_q <= 1'b0;
      size_q <= SZ_B;
      uns_q <= 1'b0;
      off_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid && req_ready) begin
          we_q <= req_we;
          size_q <= size_e'(req_size);
          uns_q <= req_unsigned;
          off_q <= req_addr[1:0];
          req_ready <= 1'b0;
          if (req_err) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state <= ACCESS;
            dm_addr <= req_addr[ADDR_W+1:2];
            dm_oe <= ~req_we;
            dm_web <= req_we ? web : WEB_NONE;
            dm_di <= req_we ? di : '0;
          end
        end
        ACCESS: if (we_q) begin
          state <= RESP;
          dm_web <= WEB_NONE;
          dm_di <= '0;
          dm_addr <= '0;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_rdata <= '0;
        end else state <= CAPTURE;
        CAPTURE: begin
          state <= RESP;
          dm_oe <= 1'b0;
          dm_addr <= '0;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_rdata <= rdata;
        end
        RESP: begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_access_unit.sv
// tb_dm_access_unit: random and directed load/store traffic against a byte-array reference model
module tb_dm_access_unit;
  logic        clk = 0, rst = 0;
  logic        req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rsp_valid, rsp_err, dm_oe;
  logic [31:0] rsp_rdata, dm_di, dm_do = 0;
  logic [3:0]  dm_web;
  logic [13:0] dm_addr;
  logic [31:0] mem [0:16383];
  logic [7:0]  rmem [0:65535];
  int          n_cmp = 0, n_bad = 0;
  int          lat, oe_n, web_n;
  logic [31:0] g_rdata, a_di;
  logic        g_err;
  logic [3:0]  a_web;
  logic [13:0] a_addr;

  dm_access_unit #(.ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dm_oe(dm_oe),
    .dm_web(dm_web), .dm_addr(dm_addr), .dm_di(dm_di), .dm_do(dm_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) if (!dm_web[k]) mem[dm_addr][8*k +: 8] <= dm_di[8*k +: 8];
    if (dm_oe) dm_do <= mem[dm_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] wd);
    int w = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    check("ready", {31'd0, req_ready}, 1);
    @(posedge clk);
    lat = 0; oe_n = 0; web_n = 0; a_web = 4'hF; a_di = 0; a_addr = 0; g_rdata = 0; g_err = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      req_valid = 0;
      if (n == 1) begin a_web = dm_web; a_di = dm_di; a_addr = dm_addr; end
      oe_n += int'(dm_oe);
      web_n += int'(dm_web != 4'hF);
      if (rsp_valid) begin lat = n; g_rdata = rsp_rdata; g_err = rsp_err; break; end
    end
  endtask

  task automatic run(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] wd);
    int nb = 1 << sz;
    logic err = sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
    logic [31:0] v = 0, di = 0;
    logic [15:0] base = a[15:0];
    int e_lat, e_oe, e_webn;
    logic [3:0] e_web = 4'hF;
    if (err) begin e_lat = 1; e_oe = 0; e_webn = 0; end
    else if (we) begin
      e_lat = 2; e_oe = 0; e_webn = 1;
      e_web = ~4'(((1 << nb) - 1) << a[1:0]);
      for (int i = 0; i < 4; i++) di[8*i +: 8] = wd[8*(i % nb) +: 8];
      for (int i = 0; i < nb; i++) rmem[base + 16'(i)] = wd[8*i +: 8];
    end else begin
      e_lat = 3; e_oe = 2; e_webn = 0;
      for (int i = 0; i < nb; i++) v |= 32'(rmem[base + 16'(i)]) << (8*i);
      if (!uns && nb < 4 && v[8*nb-1]) v |= 32'hFFFFFFFF << (8*nb);
    end
    xact(we, sz, uns, a, wd);
    check("latency", lat, e_lat);
    check("rsp_err", {31'd0, g_err}, {31'd0, err});
    check("rsp_rdata", g_rdata, v);
    check("oe_cycles", oe_n, e_oe);
    check("web_cycles", web_n, e_webn);
    check("acc_web", {28'd0, a_web}, {28'd0, e_web});
    check("acc_addr", {18'd0, a_addr}, err ? 0 : {18'd0, a[15:2]});
    if (we && !err) check("acc_di", a_di, di);
  endtask

  initial begin
    logic [31:0] hi, a;
    logic [1:0]  sz;
    int          off, seen;
    for (int i = 0; i < 16384; i++) mem[i] = 0;
    for (int i = 0; i < 65536; i++) rmem[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", {31'd0, rsp_err}, 0);
    check("rst_oe", {31'd0, dm_oe}, 0);
    check("rst_web", {28'd0, dm_web}, 32'hF);
    check("rst_addr", {18'd0, dm_addr}, 0);
    check("rst_di", dm_di, 0);
    rst = 1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 1);

    run(1, 2, 0, 32'h0000_0104, 32'hDEADBEEF);
    check("tp_sw_addr", {18'd0, a_addr}, 32'h041);
    check("tp_sw_web", {28'd0, a_web}, 32'h0);
    check("tp_sw_di", a_di, 32'hDEADBEEF);
    run(0, 0, 0, 32'h107, 0); check("tp_lb", g_rdata, 32'hFFFFFFDE);
    run(0, 0, 1, 32'h107, 0); check("tp_lbu", g_rdata, 32'h000000DE);
    run(0, 1, 0, 32'h106, 0); check("tp_lh", g_rdata, 32'hFFFFDEAD);
    run(0, 1, 1, 32'hABCD_0104, 0); check("tp_lhu_hi", g_rdata, 32'h0000BEEF);
    run(1, 0, 0, 32'h105, 32'h123456AA);
    check("tp_sb_web", {28'd0, a_web}, 32'hD);
    check("tp_sb_di", a_di, 32'hAAAAAAAA);
    run(1, 1, 0, 32'h106, 32'h0000CAFE);
    check("tp_sh_web", {28'd0, a_web}, 32'h3);
    check("tp_sh_di", a_di, 32'hCAFECAFE);
    run(0, 2, 0, 32'h104, 0); check("tp_lw", g_rdata, 32'hCAFEAAEF);
    run(0, 2, 0, 32'h102, 0); check("tp_lw_mis", {31'd0, g_err}, 1);
    run(0, 3, 0, 32'h100, 0); check("tp_bad_size", {31'd0, g_err}, 1);
    run(1, 1, 0, 32'h101, 32'h5555); check("tp_sh_mis", {31'd0, g_err}, 1);

    for (int t = 0; t < 200; t++) begin
      hi = $urandom;
      off = $urandom_range(0, 3);
      sz = $urandom_range(0, 9) == 9 ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 7) off = sz == 1 ? (off & 2) : sz == 2 ? 0 : off;
      a = {hi[31:16], 16'h0100 + 16'($urandom_range(0, 7) * 4 + off)};
      run(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2; req_unsigned = 0; req_addr = 32'h200; req_wdata = 32'h13579BDF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    check("mid_access_web", {28'd0, dm_web}, 0);
    rst = 0;
    #1;
    check("async_web", {28'd0, dm_web}, 32'hF);
    check("async_ready", {31'd0, req_ready}, 1);
    check("async_addr", {18'd0, dm_addr}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    seen = 0;
    repeat (5) begin @(negedge clk); seen += int'(rsp_valid); end
    check("dropped_no_rsp", seen, 0);
    check("dropped_ready", {31'd0, req_ready}, 1);
    check("dropped_mem", mem[14'h080], 0);
    run(0, 2, 0, 32'h200, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
Load/store front-end between the CPU data port and the data-memory SRAM wrapper.
- Accepts one CPU memory request at a time (byte/half/word, signed/unsigned loads) over a valid/ready handshake.
- Drives the SRAM with word address, active-low byte write enables, replicated write data and output enable.
- Returns aligned, sign- or zero-extended load data, or an error for misaligned/illegal requests, as a one-cycle response pulse.

Parameters:
- ADDR_W, 14, SRAM word-address width; dm_addr = req_addr[ADDR_W+1:2], higher address bits ignored.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal size, qualified by rsp_valid
- dm_oe  out  1  SRAM output enable, active-high
- dm_web  out  4  SRAM byte write enables, active-low, bit k = byte lane k
- dm_addr  out  ADDR_W  SRAM word address
- dm_di  out  32  SRAM write data
- dm_do  in  32  SRAM read data; valid the cycle after the address/oe edge

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, dm_oe=0, dm_web=4'b1111, dm_addr=0, dm_di=0.
- All SRAM-side outputs come from registers or state-decoded registers. They hold idle values (oe=0, web=1111, addr/di=0) outside ACCESS and CAPTURE.

FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: on req_valid && req_ready, register we/size/unsigned/addr/wdata.
  - Legal request -> ACCESS.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11 -> RESP with err=1, rdata=0, and no SRAM activity.
- ACCESS: dm_addr driven.
  - Store: dm_web = lane mask for exactly this one cycle, dm_di = replicated data -> RESP.
  - Load: dm_oe=1 -> CAPTURE.
- CAPTURE (loads only): dm_oe held 1.
  - Extract lane from dm_do, extend, register into rsp_rdata -> RESP.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. req_ready=0.

Latency, with accept edge at cycle T:
- Store: rsp_valid in cycle T+2.
- Load: rsp_valid in cycle T+3.
- Error: rsp_valid in cycle T+1.
- Back-to-back requests are separated by at least one IDLE cycle.

Lane rules (little-endian, k = addr[1:0]):
- Byte store: web = ~(4'b0001<<k), di = {4{wdata[7:0]}}.
- Half store: k=0 -> web=1100; k=2 -> web=0011; di = {2{wdata[15:0]}}.
- Word store: web=0000, di=wdata.
- Byte load: dm_do[8k+7:8k], extended from bit 7 unless req_unsigned.
- Half load: dm_do[8k+15:8k], extended from bit 15 unless req_unsigned.
- Word load: dm_do unchanged; req_unsigned ignored.

Boundary conditions:
- req_valid while not IDLE is ignored. The CPU must hold the request until accepted.
- rsp_rdata/rsp_err hold their last value between responses.
- Reset asserted in any state returns to IDLE immediately and asynchronously; dm_web goes to 1111 at once. A pending request is dropped and no rsp_valid follows.
- Address bits above ADDR_W+1 never cause an error.

Decomposition:
- Package dm_access_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_BAD)
  - state enum (IDLE, ACCESS, CAPTURE, RESP)
  - constant WEB_NONE=4'b1111
  - function is_misaligned(size, addr[1:0])
- Sub-module dm_lane_align, purely combinational:
  - store side: web mask and replicated di from size/offset/wdata
  - load side: extracted, extended result from size/offset/unsigned/dm_do
  - the FSM top instantiates it once

Test Plan:
1. Hold rst low, toggle clk -> all outputs at reset values. Release rst -> req_ready=1.
2. SW addr 0x00000104, wdata 0xDEADBEEF -> ACCESS cycle dm_addr=0x041, dm_web=0000, dm_di=0xDEADBEEF. rsp_valid at T+2, rsp_err=0, rsp_rdata=0.
3. With word 0x041 = 0xDEADBEEF:
   - LB 0x107 -> 0xFFFFFFDE
   - LBU 0x107 -> 0x000000DE
   - LH 0x106 -> 0xFFFFDEAD
   - LHU 0x104 -> 0x0000BEEF
   - each with rsp_valid at T+3 and dm_oe high in ACCESS and CAPTURE only
4. SB 0x105 wdata 0x123456AA -> dm_web=1101, dm_di=0xAAAAAAAA. SH 0x106 wdata 0x0000CAFE -> dm_web=0011, dm_di=0xCAFECAFE. Read back word gives 0xCAFEAAEF.
5. LW 0x102, then size=11 at 0x100 -> no dm_oe/dm_web activity, rsp_valid at T+1, rsp_err=1, rsp_rdata=0.
6. rst low mid-ACCESS of SW 0x200 -> dm_web=1111 before the next edge. After release: no rsp_valid, req_ready=1, memory word 0x080 unchanged.
